// File: rtl/mem_port_scheduler_pkg.sv
// Shared load/store funct3 encodings used by the memory port scheduler.
package mem_port_scheduler_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store opcodes reuse the load width encodings.
    localparam logic [2:0] F3_SB  = F3_LB;
    localparam logic [2:0] F3_SH  = F3_LH;
    localparam logic [2:0] F3_SW  = F3_LW;

endpackage

// File: rtl/mem_align_check.sv
// Flags load/store addresses that are not naturally aligned for their access width.
module mem_align_check
    import mem_port_scheduler_pkg::*;
(
    input  logic [2:0] f3,
    input  logic [1:0] addr_lsb,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (f3)
            F3_LH, F3_LHU: misaligned = addr_lsb[0];
            F3_LW:         misaligned = |addr_lsb;
            default:       misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Arbitrates the single unified memory port between instruction fetch and load/store,
// registering returned data and producing the IF/MEM stall signals.
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int          ADDR_W         = 12,
    parameter int          MAX_DATA_BURST = 2,
    parameter logic [31:0] NOP_INSTR      = 32'h00000033
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_f3,
    input  logic [31:0]       m_rdata,
    output logic              m_sclk,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic              m_read,
    output logic              m_write,
    output logic [2:0]        m_f3,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       load_data,
    output logic              data_done,
    output logic              misaligned,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_FETCH,
        GRANT_DATA
    } grant_e;

    localparam int                CNT_W     = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_DATA_BURST);

    grant_e           grant;
    logic [CNT_W-1:0] burst_cnt;
    logic             served;
    logic             data_pend;
    logic             addr_bad;

    mem_align_check u_align (
        .f3         (d_f3),
        .addr_lsb   (d_addr[1:0]),
        .misaligned (addr_bad)
    );

    assign data_pend = (d_read | d_write) & ~served;

    always_comb begin
        grant = GRANT_IDLE;
        if (data_pend && (!fetch_req || burst_cnt < BURST_MAX)) begin
            grant = GRANT_DATA;
        end else if (fetch_req) begin
            grant = GRANT_FETCH;
        end
    end

    // Read+write together behaves as a store; writes are additionally held off during reset.
    always_comb begin
        m_sclk  = 1'b1;
        m_addr  = pc;
        m_wdata = d_wdata;
        m_f3    = d_f3;
        m_read  = 1'b0;
        m_write = 1'b0;
        if (grant == GRANT_DATA) begin
            m_sclk  = 1'b0;
            m_addr  = d_addr;
            m_read  = d_read & ~d_write & ~addr_bad;
            m_write = d_write & ~addr_bad & rst;
        end
    end

    assign stall_if  = fetch_req & (grant != GRANT_FETCH);
    assign stall_mem = data_pend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            load_data   <= '0;
            data_done   <= 1'b0;
            misaligned  <= 1'b0;
            burst_cnt   <= '0;
            served      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            data_done   <= 1'b0;
            misaligned  <= 1'b0;
            served      <= 1'b0;
            case (grant)
                GRANT_FETCH: begin
                    instr       <= m_rdata;
                    instr_valid <= 1'b1;
                    burst_cnt   <= '0;
                end
                GRANT_DATA: begin
                    data_done  <= 1'b1;
                    served     <= 1'b1;
                    misaligned <= addr_bad;
                    if (addr_bad) begin
                        load_data <= '0;
                    end else if (!d_write) begin
                        load_data <= m_rdata;
                    end
                    if (burst_cnt != BURST_MAX) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Scoreboard bench for mem_port_scheduler with a behavioural unified memory attached.
module tb_mem_port_scheduler;

    localparam int          ADDR_W = 12;
    localparam logic [31:0] NOP    = 32'h00000033;
    localparam logic [2:0]  LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic [ADDR_W-1:0] pc;
    logic              d_read, d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [2:0]        d_f3;
    logic [31:0]       m_rdata;
    logic              m_sclk;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_read, m_write;
    logic [2:0]        m_f3;
    logic [31:0]       instr, load_data;
    logic              instr_valid, data_done, misaligned, stall_if, stall_mem;

    mem_port_scheduler #(
        .ADDR_W         (ADDR_W),
        .MAX_DATA_BURST (2),
        .NOP_INSTR      (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_f3        (d_f3),
        .m_rdata     (m_rdata),
        .m_sclk      (m_sclk),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_read      (m_read),
        .m_write     (m_write),
        .m_f3        (m_f3),
        .instr       (instr),
        .instr_valid (instr_valid),
        .load_data   (load_data),
        .data_done   (data_done),
        .misaligned  (misaligned),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem)
    );

    always #5 clk = ~clk;

    // Behavioural memory: word-addressed instruction region, byte-addressed data region.
    logic [31:0] imem [0:1023];
    logic [7:0]  dmem [0:4095];
    int          wr_count = 0;

    always_comb begin
        logic [31:0] w;
        w = {dmem[m_addr + 12'd3], dmem[m_addr + 12'd2], dmem[m_addr + 12'd1], dmem[m_addr]};
        m_rdata = '0;
        if (m_sclk) begin
            m_rdata = imem[m_addr[ADDR_W-1:2]];
        end else if (m_read) begin
            case (m_f3)
                LB:      m_rdata = {{24{w[7]}}, w[7:0]};
                LH:      m_rdata = {{16{w[15]}}, w[15:0]};
                LW:      m_rdata = w;
                LBU:     m_rdata = {24'h0, w[7:0]};
                LHU:     m_rdata = {16'h0, w[15:0]};
                default: m_rdata = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (m_write && !m_sclk) begin
            wr_count <= wr_count + 1;
            dmem[m_addr] <= m_wdata[7:0];
            if (m_f3[1:0] != 2'b00) dmem[m_addr + 12'd1] <= m_wdata[15:8];
            if (m_f3[1:0] == 2'b10) begin
                dmem[m_addr + 12'd2] <= m_wdata[23:16];
                dmem[m_addr + 12'd3] <= m_wdata[31:24];
            end
        end
    end

    typedef struct packed {
        logic [31:0] load;
        logic        mis;
    } data_exp_t;

    logic [31:0] instr_q [$];
    data_exp_t   data_q  [$];
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] last_load = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (instr_valid) begin
                if (instr_q.size() == 0) begin
                    check("unexpected instr_valid", 32'd1, 32'd0);
                end else begin
                    check("instr", instr, instr_q.pop_front());
                end
            end
            if (data_done) begin
                if (data_q.size() == 0) begin
                    check("unexpected data_done", 32'd1, 32'd0);
                end else begin
                    data_exp_t e;
                    e = data_q.pop_front();
                    check("load_data", load_data, e.load);
                    check("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_once(input logic [ADDR_W-1:0] p);
        instr_q.push_back(imem[p[ADDR_W-1:2]]);
        fetch_req = 1'b1;
        pc = p;
        @(negedge clk);
        check("fetch stall_if", {31'h0, stall_if}, 32'd0);
        check("fetch m_addr", {20'h0, m_addr}, {20'h0, p});
        tick();
        fetch_req = 1'b0;
        tick();
    endtask

    // Issues one data request, expects it granted in its first cycle, waits for data_done.
    task automatic do_data(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [2:0] f3, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic mis);
        data_exp_t e;
        logic      done;
        e.load = mis ? 32'h0 : (wr ? last_load : exp_rd);
        e.mis  = mis;
        data_q.push_back(e);
        last_load = e.load;
        d_read = rd; d_write = wr; d_addr = a; d_f3 = f3; d_wdata = wd;
        @(negedge clk);
        check("m_read", {31'h0, m_read}, {31'h0, rd & ~wr & ~mis});
        check("m_write", {31'h0, m_write}, {31'h0, wr & ~mis});
        check("stall_mem", {31'h0, stall_mem}, 32'd1);
        check("stall_if on data", {31'h0, stall_if}, {31'h0, fetch_req});
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            tick();
            done = data_done;
        end
        if (!done) check("data_done timeout", 32'd0, 32'd1);
        d_read = 1'b0; d_write = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        for (int i = 0; i < 4096; i++) dmem[i] = 8'h0;
        imem[0] = 32'h00000013;
        imem[1] = 32'h00002083;
        imem[2] = 32'h00402103;
        dmem[0] = 8'd17;

        rst = 1'b0; fetch_req = 1'b0; pc = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_f3 = '0;
        tick(); tick();
        @(negedge clk);
        check("reset instr", instr, NOP);
        check("reset load_data", load_data, 32'h0);
        check("reset pulses", {29'h0, instr_valid, data_done, misaligned}, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        fetch_once(12'd4);

        // Load word concurrent with a fetch: data first, fetch in the following cycle.
        fetch_req = 1'b1; pc = 12'd8;
        instr_q.push_back(32'h00402103);
        do_data(1'b1, 1'b0, 12'd0, LW, 32'h0, 32'd17, 1'b0);
        fetch_req = 1'b0;
        tick();

        do_data(1'b0, 1'b1, 12'd12, LW, 32'd51, 32'h0, 1'b0);
        do_data(1'b1, 1'b0, 12'd12, LW, 32'h0, 32'd51, 1'b0);
        do_data(1'b0, 1'b1, 12'd12, LW, 32'hFFFFFF80, 32'h0, 1'b0);
        do_data(1'b1, 1'b0, 12'd12, LB, 32'h0, 32'hFFFFFF80, 1'b0);
        do_data(1'b1, 1'b0, 12'd12, LBU, 32'h0, 32'h00000080, 1'b0);
        do_data(1'b1, 1'b0, 12'd12, LHU, 32'h0, 32'h0000FF80, 1'b0);
        do_data(1'b1, 1'b0, 12'd14, LH, 32'h0, 32'hFFFFFFFF, 1'b0);

        // Two data grants already taken without a fetch: the pending fetch must win next.
        do_data(1'b1, 1'b0, 12'd0, LW, 32'h0, 32'd17, 1'b0);
        do_data(1'b1, 1'b0, 12'd0, LW, 32'h0, 32'd17, 1'b0);
        instr_q.push_back(32'h00000013);
        data_q.push_back('{load: 32'd17, mis: 1'b0});
        last_load = 32'd17;
        fetch_req = 1'b1; pc = 12'd0;
        d_read = 1'b1; d_write = 1'b0; d_addr = 12'd0; d_f3 = LW;
        @(negedge clk);
        check("burst limit fetch granted", {30'h0, stall_if, m_sclk}, 32'd1);
        check("burst limit stall_mem", {31'h0, stall_mem}, 32'd1);
        tick();
        @(negedge clk);
        check("after fetch data granted", {30'h0, stall_if, m_sclk}, 32'd2);
        tick();
        fetch_req = 1'b0; d_read = 1'b0;
        tick();

        do_data(1'b1, 1'b0, 12'd2, LW, 32'h0, 32'h0, 1'b1);
        begin
            int wc;
            wc = wr_count;
            do_data(1'b0, 1'b1, 12'd1, LH, 32'h00001234, 32'h0, 1'b1);
            check("misaligned SH write count", 32'(wr_count - wc), 32'd0);
            check("misaligned SH memory", {dmem[3], dmem[2], dmem[1], dmem[0]}, 32'd17);
        end
        do_data(1'b1, 1'b0, 12'd0, LW, 32'h0, 32'd17, 1'b0);
        do_data(1'b1, 1'b0, 12'd3, LHU, 32'h0, 32'h0, 1'b1);
        do_data(1'b1, 1'b0, 12'd3, LB, 32'h0, 32'h0, 1'b0);
        do_data(1'b1, 1'b0, 12'd0, 3'b011, 32'h0, 32'h0, 1'b0);
        do_data(1'b1, 1'b0, 12'd0, LW, 32'h0, 32'd17, 1'b0);

        // Reset lands in the cycle a store would be granted.
        rst = 1'b0;
        d_write = 1'b1; d_addr = 12'd20; d_f3 = LW; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("m_write during reset", {31'h0, m_write}, 32'd0);
        tick();
        rst = 1'b1; d_write = 1'b0;
        @(negedge clk);
        check("post-reset instr", instr, NOP);
        check("post-reset load_data", load_data, 32'h0);
        check("post-reset pulses", {29'h0, instr_valid, data_done, misaligned}, 32'h0);
        last_load = 32'h0;
        tick();
        do_data(1'b1, 1'b0, 12'd20, LW, 32'h0, 32'h0, 1'b0);

        repeat (3) tick();
        check("instr queue drained", instr_q.size(), 32'd0);
        check("data queue drained", data_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
